// File: rtl/fifo_write_arbiter_pkg.sv
// rtl/fifo_write_arbiter_pkg.sv - shared types and helpers for the FIFO write-port arbiter
//
// Contents:
//   arb_state_t  arbiter FSM state encoding (ARB_IDLE=0, ARB_GRANT=1)
//   cnt_width()  bits needed to hold a count from 0 up to and including max_val

package fifo_write_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin winner select
//
// Ports:
//   req_valid  in   NUM_REQ          request vector
//   rr_ptr     in   $clog2(NUM_REQ)  highest-priority index for this pick
//   winner     out  $clog2(NUM_REQ)  first valid index scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ)
//   any        out  1                at least one request valid

module fifo_write_arbiter_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NREQ = (IW + 1)'(NUM_REQ);

  logic [IW:0] idx;
  logic        found;

  assign any = |req_valid;

  // Scan offsets 0..NUM_REQ-1 from rr_ptr; wrap by subtraction so NUM_REQ
  // does not have to be a power of two.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + k[IW:0];
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[IW-1:0]]) begin
        winner = idx[IW-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-locking arbiter for the async FIFO write port
//
// Ports:
//   clk_write    in   1                   write-domain clock
//   reset        in   1                   synchronous, active-high
//   req_valid    in   NUM_REQ             producer i has a word
//   req_data     in   NUM_REQ*DATA_WIDTH  producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     in   NUM_REQ             producer i word ends its burst
//   req_ready    out  NUM_REQ             one-hot or zero
//   wr_full      in   1                   FIFO full flag
//   fifo_data    out  DATA_WIDTH          FIFO data_in (0 when not writing)
//   fifo_wr_en   out  1                   FIFO Wr_enable
//   grant_id     out  $clog2(NUM_REQ)     current/last owner index
//   busy         out  1                   high while a producer owns the port
//   burst_abort  out  1                   one-cycle pulse on idle-timeout release

module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                          clk_write,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wr_full,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_wr_en,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          burst_abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = cnt_width(MAX_BURST);
  localparam int TW = cnt_width(IDLE_TIMEOUT);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);

  arb_state_t              state, state_nxt;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           grant_q;
  logic [IW-1:0]           winner;
  logic                    any_valid;
  logic [BW-1:0]           beat_cnt;
  logic [TW-1:0]           idle_cnt;

  logic                    owner_valid;
  logic                    owner_last;
  logic [DATA_WIDTH-1:0]   owner_data;
  logic                    xfer;
  logic                    timeout;
  logic                    release_grant;

  fifo_write_arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .any      (any_valid)
  );

  // Owner's request lines selected by the registered grant index.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state plus the combinational write/abort decisions. A reset cycle
  // suppresses every write so an in-flight burst is dropped cleanly.
  always_comb begin
    state_nxt     = state;
    xfer          = 1'b0;
    timeout       = 1'b0;
    release_grant = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_valid) state_nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        xfer          = owner_valid & ~wr_full;
        // Full stalls with valid high are not idle, so they never time out.
        timeout       = ~owner_valid & (idle_cnt == IDLE_LAST);
        release_grant = (xfer & (owner_last | (beat_cnt == BEAT_LAST))) | timeout;
        if (release_grant) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (reset) begin
      xfer          = 1'b0;
      timeout       = 1'b0;
      release_grant = 1'b0;
    end
  end

  always_ff @(posedge clk_write) begin
    if (reset) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE) begin
        if (any_valid) begin
          grant_q  <= winner;
          beat_cnt <= '0;
          idle_cnt <= '0;
        end
      end else begin
        if (xfer) beat_cnt <= beat_cnt + 1'b1;
        if (owner_valid) idle_cnt <= '0;
        else             idle_cnt <= idle_cnt + 1'b1;
        if (release_grant) rr_ptr <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (grant_q == IW'(i));
    end
  end

  assign fifo_wr_en  = xfer;
  assign fifo_data   = xfer ? owner_data : '0;
  assign grant_id    = grant_q;
  assign busy        = (state == ARB_GRANT);
  assign burst_abort = timeout;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter

module tb_fifo_write_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 8;
  localparam int ITO = 16;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          wr_full;
  logic [DW-1:0] fifo_data;
  logic          fifo_wr_en;
  logic [1:0]    grant_id;
  logic          busy;
  logic          burst_abort;

  fifo_write_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(ITO)
  ) dut (
    .clk_write  (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .wr_full    (wr_full),
    .fifo_data  (fifo_data),
    .fifo_wr_en (fifo_wr_en),
    .grant_id   (grant_id),
    .busy       (busy),
    .burst_abort(burst_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic check_en = 1'b0;
  logic sb_en = 1'b0;
  int sb_cnt [N];
  int seq [N];
  logic [1:0] wr_log [$];

  // Model state: owner is -1 when nobody holds the port.
  int m_owner = -1;
  int m_rr = 0;
  int m_gid = 0;
  int m_beats = 0;
  int m_idle = 0;

  typedef struct packed {
    logic [N-1:0]  ready;
    logic          wr;
    logic [DW-1:0] data;
    logic          abort;
    logic          rel;
  } exp_t;

  exp_t e_cmp;

  function automatic exp_t model_eval();
    exp_t e;
    e = '0;
    if (!reset && m_owner >= 0) begin
      if (req_valid[m_owner] && !wr_full) begin
        e.wr = 1'b1;
        e.ready[m_owner] = 1'b1;
        e.data = req_data[m_owner*DW +: DW];
        if (req_last[m_owner] || (m_beats + 1 == MB)) e.rel = 1'b1;
      end else if (!req_valid[m_owner] && (m_idle + 1 == ITO)) begin
        e.abort = 1'b1;
        e.rel = 1'b1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin : model_step
    exp_t pe;
    int idx;
    logic found;
    if (reset) begin
      m_owner = -1; m_rr = 0; m_gid = 0; m_beats = 0; m_idle = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          m_owner = idx; m_gid = idx; m_beats = 0; m_idle = 0;
        end
      end
    end else begin
      pe = model_eval();
      if (pe.wr) m_beats = m_beats + 1;
      if (req_valid[m_owner]) m_idle = 0; else m_idle = m_idle + 1;
      if (pe.rel) begin
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      e_cmp = model_eval();
      vectors++;
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_cmp.wr));
      chk("req_ready", 32'(req_ready), 32'(e_cmp.ready));
      chk("fifo_data", 32'(fifo_data), 32'(e_cmp.data));
      chk("burst_abort", 32'(burst_abort), 32'(e_cmp.abort));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("wr_while_full", 32'(fifo_wr_en & wr_full), 32'd0);
      chk("ready_onehot", 32'($countones(req_ready) > 1), 32'd0);
      if (fifo_wr_en) begin
        wr_log.push_back(grant_id);
        if (sb_en) begin
          chk("sb_order", 32'(fifo_data), 32'((int'(grant_id) << 6) | (sb_cnt[grant_id] & 63)));
          sb_cnt[grant_id] = sb_cnt[grant_id] + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    wr_full = 1'b0;
    req_data = 32'h44332211;
    tick();
    check_en = 1'b1;
    tick();
    reset = 1'b0;
    wr_log.delete();
  endtask

  logic [1:0] exp2 [5];
  logic [N-1:0] hs;

  initial begin
    exp2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset values
    do_reset();
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_abort", 32'(burst_abort), 32'd0);

    // All valid, all single-beat: grants rotate 0,1,2,3,0 every 2 cycles
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int c = 0; c < 10; c++) tick();
    chk("rr_count", 32'(wr_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < wr_log.size()) chk("rr_order", 32'(wr_log[i]), 32'(exp2[i]));

    // Max-burst release: 8 beats from 0, then waiting producer 1
    do_reset();
    req_valid = 4'b0011; req_last = 4'b0010;
    for (int c = 0; c < 11; c++) tick();
    chk("burst_count", 32'(wr_log.size()), 32'd9);
    for (int i = 0; i < 8; i++)
      if (i < wr_log.size()) chk("burst_owner0", 32'(wr_log[i]), 32'd0);
    if (wr_log.size() > 8) chk("burst_next1", 32'(wr_log[8]), 32'd1);

    // Idle timeout: owner 1 sends 3 beats then goes quiet for 16 cycles
    do_reset();
    req_valid = 4'b0010;
    tick();
    for (int b = 0; b < 3; b++) begin
      #3 chk("to_write", 32'(fifo_wr_en), 32'd1);
      tick();
    end
    req_valid = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      #3 chk("to_abort", 32'(burst_abort), 32'(k == 16));
      tick();
    end
    #3 chk("to_idle_busy", 32'(busy), 32'd0);
    tick();

    // Full stall mid-burst: no writes, no abort, beat count held
    do_reset();
    req_valid = 4'b0001;
    tick(); tick(); tick();
    wr_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("full_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("full_abort", 32'(burst_abort), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      tick();
    end
    wr_full = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    #3;
    chk("full_total_beats", 32'(wr_log.size()), 32'd8);
    chk("full_release_busy", 32'(busy), 32'd0);
    tick();

    // Reset mid-burst: owner 2 at beat 3
    do_reset();
    req_valid = 4'b0100;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    #3 chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    tick();
    reset = 1'b0;
    #3;
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick();

    // Random traffic with per-producer order scoreboard
    do_reset();
    for (int i = 0; i < N; i++) begin
      sb_cnt[i] = 0;
      seq[i] = 0;
    end
    sb_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 3) == 0);
        req_data[i*DW +: DW] = 8'((i << 6) | (seq[i] & 63));
      end
      wr_full = ($urandom_range(0, 4) == 0);
      #3;
      hs = req_ready & req_valid;
      tick();
      for (int i = 0; i < N; i++)
        if (hs[i]) seq[i] = seq[i] + 1;
    end
    sb_en = 1'b0;
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
